// File: rtl/gpio_ahb_ext_pkg.sv
// Shared definitions for the gpio_ahb_ext AHB-Lite GPIO: register word offsets,
// interrupt encodings, AHB transfer codes and byte-lane helpers.
package gpio_ahb_ext_pkg;

  // Word offsets, i.e. haddr[5:2]
  localparam logic [3:0] REG_GPI      = 4'h0;
  localparam logic [3:0] REG_GPO      = 4'h1;
  localparam logic [3:0] REG_GPD      = 4'h2;
  localparam logic [3:0] REG_GPO_SET  = 4'h3;
  localparam logic [3:0] REG_GPO_CLR  = 4'h4;
  localparam logic [3:0] REG_GPO_TGL  = 4'h5;
  localparam logic [3:0] REG_IRQ_EN   = 4'h6;
  localparam logic [3:0] REG_IRQ_TYPE = 4'h7;
  localparam logic [3:0] REG_IRQ_POL  = 4'h8;
  localparam logic [3:0] REG_IRQ_PEND = 4'h9;
  localparam logic [3:0] REG_DB_DIV   = 4'hA;

  localparam logic IRQ_TYPE_LEVEL = 1'b0;
  localparam logic IRQ_TYPE_EDGE  = 1'b1;
  localparam logic IRQ_POL_LOW    = 1'b0;
  localparam logic IRQ_POL_HIGH   = 1'b1;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam int DB_DIV_W = 16;

  typedef struct packed {
    logic       valid;
    logic       write;
    logic [3:0] addr;
    logic [3:0] strb;
  } dphase_t;

  function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] s;
    case (size)
      HSIZE_BYTE: s = 4'b0001 << lane;
      HSIZE_HALF: s = lane[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: s = 4'b1111;
      default:    s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/gpio_ahb_ext_if.sv
// AHB-Lite slave-port bundle for gpio_ahb_ext.
interface gpio_ahb_ext_if #(
  parameter int addr_w = 6
);
  logic              hsel;
  logic [addr_w-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [31:0]       hwdata;
  logic [31:0]       hrdata;
  logic              hready;
  logic [1:0]        hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/gpio_ahb_ext_filter.sv
// Input conditioning: 2-flop synchronizer, then either a plain register or, with
// GPIO_AHB_EXT_DEBOUNCE_EN defined, a prescaled 3-sample debounce per pin.
module gpio_ahb_ext_filter
  import gpio_ahb_ext_pkg::*;
#(
  parameter int gpio_w = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
`ifdef GPIO_AHB_EXT_DEBOUNCE_EN
  input  logic [DB_DIV_W-1:0] db_div_i,
  input  logic                db_restart_i,
`endif
  input  logic [gpio_w-1:0]   gpi_i,
  output logic [gpio_w-1:0]   gpi_f_o
);

  logic [gpio_w-1:0] sync1_q, sync2_q, gpi_f_q, gpi_f_d;

`ifdef GPIO_AHB_EXT_DEBOUNCE_EN
  logic [DB_DIV_W-1:0] cnt_q, cnt_d;
  logic [gpio_w-1:0]   h0_q, h0_d, h1_q, h1_d, stable_s;
  logic                strobe_s;

  // A pin follows the synchronizer only once three consecutive strobes agree.
  always_comb begin
    strobe_s = !db_restart_i && (cnt_q == db_div_i);
    if (db_restart_i || strobe_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DB_DIV_W'(1);
    end
    stable_s = ~(sync2_q ^ h0_q) & ~(h0_q ^ h1_q);
    if (strobe_s) begin
      h0_d    = sync2_q;
      h1_d    = h0_q;
      gpi_f_d = (stable_s & sync2_q) | (~stable_s & gpi_f_q);
    end else begin
      h0_d    = h0_q;
      h1_d    = h1_q;
      gpi_f_d = gpi_f_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      h0_q  <= '0;
      h1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      h0_q  <= h0_d;
      h1_q  <= h1_d;
    end
  end
`else
  assign gpi_f_d = sync2_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      gpi_f_q <= '0;
    end else begin
      sync1_q <= gpi_i;
      sync2_q <= sync1_q;
      gpi_f_q <= gpi_f_d;
    end
  end

  assign gpi_f_o = gpi_f_q;

endmodule

// File: rtl/gpio_ahb_ext.sv
// Zero-wait-state AHB-Lite GPIO with atomic SET/CLR/TGL, byte lanes and maskable
// level/edge interrupts. GPIO_AHB_EXT_DEBOUNCE_EN enables the input debounce and DB_DIV.
module gpio_ahb_ext
  import gpio_ahb_ext_pkg::*;
#(
  parameter int gpio_w = 8,
  parameter int addr_w = 6
) (
  input  logic              hclk,
  input  logic              hresetn,
  gpio_ahb_ext_if.slave     ahb,
  output logic              irq,
  input  logic [gpio_w-1:0] gpi,
  output logic [gpio_w-1:0] gpo,
  output logic [gpio_w-1:0] gpd
);

  logic [addr_w-1:0] haddr_s;
  dphase_t           dph_d, dph_q;
  logic [gpio_w-1:0] gpo_d, gpo_q, gpd_d, gpd_q, en_d, en_q;
  logic [gpio_w-1:0] type_d, type_q, pol_d, pol_q, pend_d, pend_q;
  logic [gpio_w-1:0] gpi_f_s, gpi_q, wbits_s, w1c_s, evt_s;
  logic [31:0]       mask_s;
  logic              wr_s, irq_d, irq_q, unused_s;
`ifdef GPIO_AHB_EXT_DEBOUNCE_EN
  logic [DB_DIV_W-1:0] db_div_d, db_div_q;
  logic                db_restart_s;
`endif

  assign haddr_s  = ahb.haddr;
  assign unused_s = ^{ahb.hburst, ahb.hwdata, haddr_s, ahb.hsize, mask_s};

  gpio_ahb_ext_filter #(.gpio_w(gpio_w)) u_filter (
    .clk_i        (hclk),
    .rst_ni       (hresetn),
`ifdef GPIO_AHB_EXT_DEBOUNCE_EN
    .db_div_i     (db_div_q),
    .db_restart_i (db_restart_s),
`endif
    .gpi_i        (gpi),
    .gpi_f_o      (gpi_f_s)
  );

  // Address-phase capture; IDLE and BUSY leave the data phase empty.
  always_comb begin
    dph_d = '0;
    if (ahb.hsel && (ahb.htrans == HTRANS_NONSEQ || ahb.htrans == HTRANS_SEQ)) begin
      dph_d.valid = 1'b1;
      dph_d.write = ahb.hwrite;
      dph_d.addr  = haddr_s[5:2];
      dph_d.strb  = byte_strobe(ahb.hsize, haddr_s[1:0]);
    end else begin
      dph_d = '0;
    end
  end

  assign wr_s    = dph_q.valid && dph_q.write;
  assign mask_s  = lane_mask(dph_q.strb);
  assign wbits_s = ahb.hwdata[gpio_w-1:0] & mask_s[gpio_w-1:0];

  // Per-pin interrupt event, evaluated every cycle regardless of IRQ_EN.
  always_comb begin
    evt_s = '0;
    for (int i = 0; i < gpio_w; i++) begin
      case (type_q[i])
        IRQ_TYPE_LEVEL: evt_s[i] = (pol_q[i] == IRQ_POL_LOW) ? ~gpi_f_s[i] : gpi_f_s[i];
        IRQ_TYPE_EDGE:  evt_s[i] = (pol_q[i] == IRQ_POL_HIGH) ? (gpi_f_s[i] & ~gpi_q[i])
                                                              : (~gpi_f_s[i] & gpi_q[i]);
        default:        evt_s[i] = 1'b0;
      endcase
    end
  end

  // Register file next state; unstrobed lanes keep their value.
  always_comb begin
    gpo_d  = gpo_q;
    gpd_d  = gpd_q;
    en_d   = en_q;
    type_d = type_q;
    pol_d  = pol_q;
    w1c_s  = '0;
`ifdef GPIO_AHB_EXT_DEBOUNCE_EN
    db_div_d     = db_div_q;
    db_restart_s = 1'b0;
`endif
    if (wr_s) begin
      case (dph_q.addr)
        REG_GPO:      gpo_d  = (gpo_q & ~mask_s[gpio_w-1:0]) | wbits_s;
        REG_GPD:      gpd_d  = (gpd_q & ~mask_s[gpio_w-1:0]) | wbits_s;
        REG_GPO_SET:  gpo_d  = gpo_q | wbits_s;
        REG_GPO_CLR:  gpo_d  = gpo_q & ~wbits_s;
        REG_GPO_TGL:  gpo_d  = gpo_q ^ wbits_s;
        REG_IRQ_EN:   en_d   = (en_q & ~mask_s[gpio_w-1:0]) | wbits_s;
        REG_IRQ_TYPE: type_d = (type_q & ~mask_s[gpio_w-1:0]) | wbits_s;
        REG_IRQ_POL:  pol_d  = (pol_q & ~mask_s[gpio_w-1:0]) | wbits_s;
        REG_IRQ_PEND: w1c_s  = wbits_s;
`ifdef GPIO_AHB_EXT_DEBOUNCE_EN
        REG_DB_DIV: begin
          db_div_d     = (db_div_q & ~mask_s[DB_DIV_W-1:0]) | (ahb.hwdata[DB_DIV_W-1:0] & mask_s[DB_DIV_W-1:0]);
          db_restart_s = 1'b1;
        end
`endif
        default: w1c_s = '0;
      endcase
    end else begin
      w1c_s = '0;
    end
    // A coincident event beats the clear.
    pend_d = (pend_q & ~w1c_s) | evt_s;
    irq_d  = |(pend_q & en_q);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dph_q  <= '0;
      gpo_q  <= '0;
      gpd_q  <= '0;
      en_q   <= '0;
      type_q <= '0;
      pol_q  <= '0;
      pend_q <= '0;
      gpi_q  <= '0;
      irq_q  <= 1'b0;
`ifdef GPIO_AHB_EXT_DEBOUNCE_EN
      db_div_q <= '0;
`endif
    end else begin
      dph_q  <= dph_d;
      gpo_q  <= gpo_d;
      gpd_q  <= gpd_d;
      en_q   <= en_d;
      type_q <= type_d;
      pol_q  <= pol_d;
      pend_q <= pend_d;
      gpi_q  <= gpi_f_s;
      irq_q  <= irq_d;
`ifdef GPIO_AHB_EXT_DEBOUNCE_EN
      db_div_q <= db_div_d;
`endif
    end
  end

  // Read data follows the captured address and live register state.
  always_comb begin
    ahb.hrdata = 32'h0000_0000;
    if (dph_q.valid && !dph_q.write) begin
      case (dph_q.addr)
        REG_GPI:      ahb.hrdata = 32'(gpi_f_s);
        REG_GPO:      ahb.hrdata = 32'(gpo_q);
        REG_GPD:      ahb.hrdata = 32'(gpd_q);
        REG_IRQ_EN:   ahb.hrdata = 32'(en_q);
        REG_IRQ_TYPE: ahb.hrdata = 32'(type_q);
        REG_IRQ_POL:  ahb.hrdata = 32'(pol_q);
        REG_IRQ_PEND: ahb.hrdata = 32'(pend_q);
`ifdef GPIO_AHB_EXT_DEBOUNCE_EN
        REG_DB_DIV:   ahb.hrdata = 32'(db_div_q);
`endif
        default:      ahb.hrdata = 32'h0000_0000;
      endcase
    end else begin
      ahb.hrdata = 32'h0000_0000;
    end
  end

  assign ahb.hready = 1'b1;
  assign ahb.hresp  = 2'b00;
  assign gpo        = gpo_q;
  assign gpd        = gpd_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_ahb_ext.sv
// Directed bench for gpio_ahb_ext (gpio_w=16): register table plus interrupt and
// debounce sequences; debounce checks compile in with GPIO_AHB_EXT_DEBOUNCE_EN.
module tb_gpio_ahb_ext;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;
  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_BUSY = 2'b01;
  localparam logic [1:0] TR_NSEQ = 2'b10;
`ifdef GPIO_AHB_EXT_DEBOUNCE_EN
  localparam int LAT = 2;
  localparam logic [31:0] DB_EXP = 32'h0000_1234;
`else
  localparam int LAT = 0;
  localparam logic [31:0] DB_EXP = 32'h0000_0000;
`endif

  typedef struct {
    logic        wr;
    logic [1:0]  tr;
    logic [7:0]  addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic        hclk;
  logic        hresetn;
  logic        irq;
  logic [15:0] gpi, gpo, gpd;
  int          n_tests = 0;
  int          n_fail  = 0;
  vec_t        vt[$];

  gpio_ahb_ext_if #(.addr_w(6)) bus ();

  gpio_ahb_ext #(.gpio_w(16), .addr_w(6)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .ahb     (bus),
    .irq     (irq),
    .gpi     (gpi),
    .gpo     (gpo),
    .gpd     (gpd)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic vec_t mk(input logic wr, input logic [1:0] tr, input logic [7:0] a,
                              input logic [2:0] sz, input logic [31:0] d, input logic [31:0] e,
                              input string nm);
    vec_t v;
    v.wr = wr; v.tr = tr; v.addr = a; v.size = sz; v.data = d; v.exp = e; v.name = nm;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic addr_phase(input logic [7:0] a, input logic w, input logic [2:0] sz, input logic [1:0] tr);
    bus.hsel = 1'b1; bus.htrans = tr; bus.haddr = a[5:0]; bus.hwrite = w; bus.hsize = sz;
  endtask

  task automatic idle();
    bus.hsel = 1'b0; bus.htrans = TR_IDLE; bus.hwrite = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [2:0] sz, input logic [1:0] tr);
    @(negedge hclk); addr_phase(a, 1'b1, sz, tr);
    @(negedge hclk); bus.hwdata = d; idle();
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string nm);
    @(negedge hclk); addr_phase(a, 1'b0, SZ_W, TR_NSEQ);
    @(negedge hclk); idle(); #1;
    check(nm, bus.hrdata, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge hclk);
  endtask

  task automatic run_table();
    foreach (vt[i]) begin
      if (vt[i].wr) bus_write(vt[i].addr, vt[i].data, vt[i].size, vt[i].tr);
      else          bus_read(vt[i].addr, vt[i].exp, vt[i].name);
    end
    vt.delete();
  endtask

  initial begin
    hresetn = 1'b0; gpi = '0; bus.hwdata = '0; bus.hburst = 3'b000; bus.haddr = '0; bus.hsize = SZ_W;
    idle();
    cycles(3);
    hresetn = 1'b1;

    // Mid-write reset must clear outputs and abort the pending data phase
    bus_write(8'h04, 32'h0000_00FF, SZ_W, TR_NSEQ);
    bus_write(8'h08, 32'h0000_00FF, SZ_W, TR_NSEQ);
    cycles(1); #1;
    check("gpo_pre_reset", 32'(gpo), 32'h0000_00FF);
    @(negedge hclk); addr_phase(8'h04, 1'b1, SZ_W, TR_NSEQ);
    @(negedge hclk); bus.hwdata = 32'h0000_005A; idle(); hresetn = 1'b0; #1;
    check("gpo_reset", 32'(gpo), 32'h0);
    check("gpd_reset", 32'(gpd), 32'h0);
    check("irq_reset", 32'(irq), 32'h0);
    check("hready_hresp", {31'd0, bus.hready} | 32'(bus.hresp), 32'h0000_0001);
    @(negedge hclk); hresetn = 1'b1;

    vt.push_back(mk(1'b0, TR_NSEQ, 8'h00, SZ_W, 32'h0, 32'h0, "rst_gpi"));
    vt.push_back(mk(1'b0, TR_NSEQ, 8'h04, SZ_W, 32'h0, 32'h0, "rst_gpo"));
    vt.push_back(mk(1'b0, TR_NSEQ, 8'h08, SZ_W, 32'h0, 32'h0, "rst_gpd"));
    vt.push_back(mk(1'b0, TR_NSEQ, 8'h18, SZ_W, 32'h0, 32'h0, "rst_en"));
    vt.push_back(mk(1'b0, TR_NSEQ, 8'h1C, SZ_W, 32'h0, 32'h0, "rst_type"));
    vt.push_back(mk(1'b0, TR_NSEQ, 8'h20, SZ_W, 32'h0, 32'h0, "rst_pol"));
    vt.push_back(mk(1'b0, TR_NSEQ, 8'h28, SZ_W, 32'h0, 32'h0, "rst_dbdiv"));
    // Reset type/polarity is level-low, so every low pin latches pending right away
    vt.push_back(mk(1'b0, TR_NSEQ, 8'h24, SZ_W, 32'h0, 32'h0000_FFFF, "rst_pend_level_low"));
    vt.push_back(mk(1'b1, TR_NSEQ, 8'h04, SZ_W, 32'h0000_00A5, 32'h0, ""));
    vt.push_back(mk(1'b1, TR_NSEQ, 8'h0C, SZ_W, 32'h0000_000F, 32'h0, ""));
    vt.push_back(mk(1'b1, TR_NSEQ, 8'h10, SZ_W, 32'h0000_0080, 32'h0, ""));
    vt.push_back(mk(1'b1, TR_NSEQ, 8'h14, SZ_W, 32'h0000_0003, 32'h0, ""));
    vt.push_back(mk(1'b0, TR_NSEQ, 8'h04, SZ_W, 32'h0, 32'h0000_002C, "set_clr_tgl"));
    vt.push_back(mk(1'b0, TR_NSEQ, 8'h0C, SZ_W, 32'h0, 32'h0, "wo_reads_zero"));
    vt.push_back(mk(1'b1, TR_NSEQ, 8'h05, SZ_B, 32'hFFFF_FFFF, 32'h0, ""));
    vt.push_back(mk(1'b0, TR_NSEQ, 8'h04, SZ_W, 32'h0, 32'h0000_FF2C, "byte_lane1"));
    vt.push_back(mk(1'b1, TR_NSEQ, 8'h04, SZ_W, 32'hFFFF_FFFF, 32'h0, ""));
    vt.push_back(mk(1'b0, TR_NSEQ, 8'h04, SZ_W, 32'h0, 32'h0000_FFFF, "upper_bits_zero"));
    vt.push_back(mk(1'b1, TR_IDLE, 8'h04, SZ_W, 32'h0, 32'h0, ""));
    vt.push_back(mk(1'b1, TR_BUSY, 8'h04, SZ_W, 32'h0, 32'h0, ""));
    vt.push_back(mk(1'b0, TR_NSEQ, 8'h04, SZ_W, 32'h0, 32'h0000_FFFF, "idle_busy_ignored"));
    vt.push_back(mk(1'b1, TR_NSEQ, 8'h06, SZ_H, 32'h0, 32'h0, ""));
    vt.push_back(mk(1'b0, TR_NSEQ, 8'h04, SZ_W, 32'h0, 32'h0000_FFFF, "half_upper_lane"));
    vt.push_back(mk(1'b1, TR_NSEQ, 8'h04, SZ_H, 32'hFFFF_1200, 32'h0, ""));
    vt.push_back(mk(1'b0, TR_NSEQ, 8'h04, SZ_W, 32'h0, 32'h0000_1200, "half_lower_lane"));
    vt.push_back(mk(1'b1, TR_NSEQ, 8'h11, SZ_B, 32'hFFFF_FFFF, 32'h0, ""));
    vt.push_back(mk(1'b0, TR_NSEQ, 8'h04, SZ_W, 32'h0, 32'h0000_0000, "clr_byte_lane"));
    vt.push_back(mk(1'b1, TR_NSEQ, 8'h0C, SZ_W, 32'h0001_8001, 32'h0, ""));
    vt.push_back(mk(1'b0, TR_NSEQ, 8'h04, SZ_W, 32'h0, 32'h0000_8001, "set_word"));
    vt.push_back(mk(1'b1, TR_NSEQ, 8'h08, SZ_W, 32'h0000_1234, 32'h0, ""));
    vt.push_back(mk(1'b0, TR_NSEQ, 8'h08, SZ_W, 32'h0, 32'h0000_1234, "gpd_rw"));
    vt.push_back(mk(1'b1, TR_NSEQ, 8'h30, SZ_W, 32'hFFFF_FFFF, 32'h0, ""));
    vt.push_back(mk(1'b0, TR_NSEQ, 8'h30, SZ_W, 32'h0, 32'h0, "unmapped"));
    vt.push_back(mk(1'b1, TR_NSEQ, 8'h00, SZ_W, 32'hFFFF_FFFF, 32'h0, ""));
    vt.push_back(mk(1'b0, TR_NSEQ, 8'h00, SZ_W, 32'h0, 32'h0, "gpi_ro"));
    vt.push_back(mk(1'b1, TR_NSEQ, 8'h28, SZ_W, 32'hFFFF_1234, 32'h0, ""));
    vt.push_back(mk(1'b0, TR_NSEQ, 8'h28, SZ_W, 32'h0, DB_EXP, "dbdiv_rw"));
    vt.push_back(mk(1'b1, TR_NSEQ, 8'h28, SZ_W, 32'h0, 32'h0, ""));
    run_table();
    cycles(1); #1;
    check("gpo_pins", 32'(gpo), 32'h0000_8001);
    check("gpd_pins", 32'(gpd), 32'h0000_1234);

    // Write then read of the same register back to back
    @(negedge hclk); addr_phase(8'h08, 1'b1, SZ_W, TR_NSEQ);
    @(negedge hclk); bus.hwdata = 32'h0000_00C3; addr_phase(8'h08, 1'b0, SZ_W, TR_NSEQ);
    @(negedge hclk); idle(); #1;
    check("b2b_read", bus.hrdata, 32'h0000_00C3);

    // All pins rising-edge, clear stale pending, enable pin 0
    bus_write(8'h1C, 32'h0000_FFFF, SZ_W, TR_NSEQ);
    bus_write(8'h20, 32'h0000_FFFF, SZ_W, TR_NSEQ);
    bus_write(8'h24, 32'h0000_FFFF, SZ_W, TR_NSEQ);
    bus_read(8'h24, 32'h0, "pend_cleared");
    bus_write(8'h18, 32'h0000_0001, SZ_W, TR_NSEQ);

    @(negedge hclk); gpi[0] = 1'b1;
    cycles(LAT);
    @(negedge hclk); addr_phase(8'h00, 1'b0, SZ_W, TR_NSEQ);
    @(negedge hclk); #1; check("gpi_before_3rd", bus.hrdata, 32'h0); addr_phase(8'h00, 1'b0, SZ_W, TR_NSEQ);
    @(negedge hclk); #1; check("gpi_3rd_edge", bus.hrdata, 32'h0000_0001); addr_phase(8'h24, 1'b0, SZ_W, TR_NSEQ);
    @(negedge hclk); #1; check("pend_4th_edge", bus.hrdata, 32'h0000_0001);
    check("irq_not_4th", 32'(irq), 32'h0); idle();
    @(negedge hclk); #1; check("irq_5th_edge", 32'(irq), 32'h1);
    bus_write(8'h24, 32'h0000_0001, SZ_W, TR_NSEQ);
    @(negedge hclk); #1; check("irq_after_w1c", 32'(irq), 32'h1);
    @(negedge hclk); #1; check("irq_drop", 32'(irq), 32'h0);

    // Level-high on pin 3: an active level keeps pending alive through W1C
    bus_write(8'h1C, 32'h0000_FFF7, SZ_W, TR_NSEQ);
    bus_write(8'h18, 32'h0000_0008, SZ_W, TR_NSEQ);
    @(negedge hclk); gpi[3] = 1'b1;
    cycles(6 + LAT); #1; check("irq_level", 32'(irq), 32'h1);
    bus_write(8'h24, 32'h0000_0008, SZ_W, TR_NSEQ);
    @(negedge hclk); #1; check("level_w1c_irq_a", 32'(irq), 32'h1);
    @(negedge hclk); #1; check("level_w1c_irq_b", 32'(irq), 32'h1);
    bus_read(8'h24, 32'h0000_0008, "level_pend_reassert");
    @(negedge hclk); gpi[3] = 1'b0;
    cycles(5 + LAT); #1; check("level_latched", 32'(irq), 32'h1);
    bus_write(8'h24, 32'h0000_0008, SZ_W, TR_NSEQ);
    cycles(2); #1; check("level_irq_off", 32'(irq), 32'h0);

    // Falling edge on pin 2 coinciding with its W1C
    bus_write(8'h20, 32'h0000_FFFB, SZ_W, TR_NSEQ);
    @(negedge hclk); gpi[2] = 1'b1;
    cycles(5 + LAT);
    bus_write(8'h24, 32'h0000_FFFF, SZ_W, TR_NSEQ);
    bus_read(8'h24, 32'h0, "pend_pre_collision");
    @(negedge hclk); gpi[2] = 1'b0;
    cycles(1 + LAT);
    bus_write(8'h24, 32'h0000_0004, SZ_W, TR_NSEQ);
    bus_read(8'h24, 32'h0000_0004, "event_beats_w1c");

`ifdef GPIO_AHB_EXT_DEBOUNCE_EN
    // DB_DIV=4 strobes every 5 cycles; a 10-cycle pulse spans only two strobes
    bus_write(8'h24, 32'h0000_FFFF, SZ_W, TR_NSEQ);
    bus_write(8'h28, 32'h0000_0004, SZ_W, TR_NSEQ);
    @(negedge hclk); gpi[1] = 1'b1;
    cycles(10); gpi[1] = 1'b0;
    cycles(40);
    bus_read(8'h00, 32'h0000_0001, "db_glitch_gpi");
    bus_read(8'h24, 32'h0, "db_glitch_pend");
    @(negedge hclk); gpi[1] = 1'b1;
    cycles(40);
    bus_read(8'h00, 32'h0000_0003, "db_held_gpi");
    bus_read(8'h24, 32'h0000_0002, "db_held_pend");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
